// File: rtl/rv_pipe_pkg.sv
// Shared fetch-stage types and constants for the 64-bit pipeline.
package rv_pipe_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register for a response that lands while IF/ID is stalled.
module fetch_skid_buf
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            pop,
  input  logic            clear,
  input  logic [ILEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc_d,
  output logic            vld,
  output logic [ILEN-1:0] instr_q,
  output logic [XLEN-1:0] pc_q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld     <= 1'b0;
      instr_q <= ILEN'(NOP_INSTR);
      pc_q    <= '0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld     <= 1'b1;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end else if (pop) begin
      vld <= 1'b0;
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer: owns fetch PC, one outstanding imem request, registered IF/ID outputs.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch_unit
  import rv_pipe_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic [ILEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
`ifdef IF_MISALIGN_TRAP_EN
  , output logic          misaligned_o
`endif
);
  localparam logic [ILEN-1:0] NOP = ILEN'(NOP_INSTR);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc, req_pc, redir_pc;
  logic [ILEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q, squash, hold;
  logic            stalled, consumed, fire, outstanding;
  logic            sk_vld, sk_load, sk_pop;
  logic [ILEN-1:0] sk_instr;
  logic [XLEN-1:0] sk_pc;

`ifdef IF_MISALIGN_TRAP_EN
  logic mis_q;
  logic redir_mis;
  assign redir_mis    = redirect_pc_i[1:0] != 2'b00;
  assign redir_pc     = redirect_pc_i;
  assign hold         = mis_q;
  assign misaligned_o = mis_q;
`else
  assign redir_pc = redirect_pc_i & ~XLEN'(INSTR_BYTES - 1);
  assign hold     = 1'b0;
`endif

  assign stalled     = valid_q && stall_i;
  assign consumed    = valid_q && !stall_i;
  assign imem_req_o  = (state == REQ) && !stalled;
  assign imem_addr_o = fetch_pc;
  assign fire        = imem_req_o && imem_gnt_i;
  // a response is still owed if we are waiting (or squashing) and it has not arrived this cycle
  assign outstanding = (((state == WAIT) || squash) && !imem_rvalid_i) || fire;

  assign sk_load = !redirect_i && (state == WAIT) && imem_rvalid_i && !squash && stalled;
  assign sk_pop  = !redirect_i && (state == FULL) && sk_vld && consumed;

  fetch_skid_buf #(.XLEN(XLEN), .ILEN(ILEN)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (sk_load),
    .pop     (sk_pop),
    .clear   (redirect_i),
    .instr_d (imem_rdata_i),
    .pc_d    (req_pc),
    .vld     (sk_vld),
    .instr_q (sk_instr),
    .pc_q    (sk_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      instr_q  <= NOP;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      squash   <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else if (redirect_i) begin
      fetch_pc <= redir_pc;
      valid_q  <= 1'b0;
      instr_q  <= NOP;
      squash   <= outstanding;
      state    <= outstanding ? WAIT : REQ;
`ifdef IF_MISALIGN_TRAP_EN
      mis_q <= redir_mis;
      if (redir_mis) begin
        state   <= IDLE;
        valid_q <= 1'b1;
        pc_q    <= redirect_pc_i;
      end
`endif
    end else begin
      if (consumed && !hold) begin
        valid_q <= 1'b0;
        instr_q <= NOP;
      end
      case (state)
        IDLE: begin
          if (imem_rvalid_i) squash <= 1'b0;
          if (!hold) state <= REQ;
        end
        REQ: if (fire) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
          state    <= WAIT;
        end
        WAIT: if (imem_rvalid_i) begin
          if (squash) begin
            squash <= 1'b0;
            state  <= REQ;
          end else if (!stalled) begin
            instr_q <= imem_rdata_i;
            pc_q    <= req_pc;
            valid_q <= 1'b1;
            state   <= REQ;
          end else begin
            state <= FULL;
          end
        end
        FULL: if (sk_pop) begin
          instr_q <= sk_instr;
          pc_q    <= sk_pc;
          valid_q <= 1'b1;
          state   <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign instruction_o = instr_q;
  assign pc_o          = pc_q;
  assign valid_o       = valid_q;
endmodule
